// File: rtl/mips_perf_counters_if.sv
// Bus between the MIPS-lite pipeline (write-back stage, hazard unit) and the
// performance-counter unit.
//   master : pipeline side; drives control/event strobes and the read address,
//            receives read data and status.
//   slave  : counter unit; the mirror image.
// Ports carried:
//   start, clear, halt         run/halt/clear control
//   retire_valid, retire_class retirement event at WB and its class code
//   stall, hazard              per-cycle pipeline events
//   rd_addr / rd_data          registered counter read port
//   running, halted, overflow  status
interface mips_perf_counters_if #(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 4
);
    logic              start;
    logic              clear;
    logic              retire_valid;
    logic [2:0]        retire_class;
    logic              stall;
    logic              hazard;
    logic              halt;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  rd_data;
    logic              running;
    logic              halted;
    logic              overflow;

    modport master (
        output start, clear, retire_valid, retire_class, stall, hazard, halt, rd_addr,
        input  rd_data, running, halted, overflow
    );

    modport slave (
        input  start, clear, retire_valid, retire_class, stall, hazard, halt, rd_addr,
        output rd_data, running, halted, overflow
    );
endinterface

// File: rtl/mips_perf_counters.sv
// Performance-counter unit for the MIPS-lite 5-stage pipeline. Counts retired
// instructions (total and per class), cycles, stalls and data hazards, and
// captures the cycle count at HALT.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mips_perf_counters_if.slave (control, events, read port, status)
// Read map: 0 TOTAL, 1 CYCLES, 2 STALLS, 3 HAZARDS, 4 FINAL_CYCLES,
//           5+k CLASS[k]; anything else reads 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | counters hold, waiting for start
// S_RUN    | counting every cycle and every event
// S_HALTED | HALT retired; counters frozen until clear or reset
module mips_perf_counters #(
    parameter int CNT_W     = 32,
    parameter int NUM_CLASS = 4,
    parameter int SATURATE  = 0,
    parameter int ADDR_W    = $clog2(5 + NUM_CLASS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_perf_counters_if.slave  bus
);
    localparam int NUM_CNT  = 5 + NUM_CLASS;
    localparam int C_TOTAL  = 0;
    localparam int C_CYCLES = 1;
    localparam int C_STALLS = 2;
    localparam int C_HAZ    = 3;
    localparam int C_FINAL  = 4;
    localparam int C_CLASS0 = 5;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [NUM_CNT];
    logic [CNT_W-1:0]   cnt_d [NUM_CNT];
    logic [NUM_CNT-1:0] inc;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   rd_data_q, rd_data_d;
    logic               running_q, halted_q;

    // All-ones either wraps to zero or sticks, depending on the build.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return (SATURATE != 0) ? v : '0;
        return v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++)
                cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
            running_q <= (state_d == S_RUN);
            halted_q  <= (state_d == S_HALTED);
            for (int i = 0; i < NUM_CNT; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        inc     = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start)
                    state_d = S_RUN;
            end
            S_RUN: begin
                inc[C_CYCLES] = 1'b1;
                inc[C_TOTAL]  = bus.retire_valid;
                inc[C_STALLS] = bus.stall;
                inc[C_HAZ]    = bus.hazard;
                // Class codes beyond NUM_CLASS only bump TOTAL.
                for (int k = 0; k < NUM_CLASS; k++)
                    if (bus.retire_valid && (int'(bus.retire_class) == k))
                        inc[C_CLASS0 + k] = 1'b1;
                if (bus.halt)
                    state_d = S_HALTED;
            end
            default: ;
        endcase

        for (int i = 0; i < NUM_CNT; i++) begin
            if (inc[i]) begin
                cnt_d[i] = cnt_inc(cnt_q[i]);
                if (&cnt_q[i])
                    ovf_d = 1'b1;
            end
        end

        // FINAL_CYCLES captures the cycle count including the HALT cycle itself.
        if (state_q == S_RUN && bus.halt)
            cnt_d[C_FINAL] = cnt_d[C_CYCLES];

        if (bus.clear) begin
            state_d = S_IDLE;
            ovf_d   = 1'b0;
            for (int i = 0; i < NUM_CNT; i++)
                cnt_d[i] = '0;
        end
    end

    // Read mux uses the registered counters, giving one cycle of read latency.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NUM_CNT; i++)
            if (bus.rd_addr == ADDR_W'(i))
                rd_data_d = cnt_q[i];
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.running  = running_q;
    assign bus.halted   = halted_q;
    assign bus.overflow = ovf_q;
endmodule
